// File: rtl/cart_pkg.sv
// Shared types and header offsets for the cartridge download front-end.
package cart_pkg;

  typedef enum logic [1:0] {
    LD_IDLE   = 2'd0,
    LD_LOAD   = 2'd1,
    LD_FINISH = 2'd2
  } cart_ld_state_t;

  localparam logic [11:0] HDR_CGB       = 12'h142;
  localparam logic [11:0] HDR_SGB_MBC   = 12'h146;
  localparam logic [11:0] HDR_SIZES     = 12'h148;
  localparam logic [11:0] HDR_LIC       = 12'h14A;
  localparam logic [11:0] HDR_CHK_FIRST = 12'h134;
  localparam logic [11:0] HDR_CHK_LAST  = 12'h14C;
  localparam logic [11:0] LOGO_BASE     = 12'h104;

  // First byte offset past the compared logo window.
  function automatic logic [11:0] logo_end(input int words);
    return LOGO_BASE + 12'(2 * words);
  endfunction

endpackage

// File: rtl/cart_logo_probe.sv
// One logo probe: tracks whether every logo word seen in its bank equals bank 0.
// Result is combinational from registered state; no backpressure of its own.
module cart_logo_probe #(
  parameter int                ADDR_W     = 25,
  parameter int                LOGO_WORDS = 8,
  parameter logic [ADDR_W-1:0] BASE       = '0
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              clr,
  input  logic              wr,
  input  logic [ADDR_W-13:0] bank,
  input  logic [15:0]       dout,
  input  logic [15:0]       ref_word,
  output logic              match
);

  localparam int CNT_W = $clog2(LOGO_WORDS + 1);

  logic             ok;
  logic [CNT_W-1:0] cnt;
  logic             hit;

  assign hit = wr && (bank == BASE[ADDR_W-1:12]);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ok  <= 1'b0;
      cnt <= '0;
    end else if (clr) begin
      ok  <= 1'b1;
      cnt <= '0;
    end else if (hit) begin
      if (dout != ref_word) ok <= 1'b0;
      if (cnt != CNT_W'(LOGO_WORDS)) cnt <= cnt + CNT_W'(1);
    end
  end

  // A bank never fully written (image too short) can not count as a match.
  assign match = ok && (cnt == CNT_W'(LOGO_WORDS));

endmodule

// File: rtl/cart_hdr_loader.sv
// Cartridge download front-end: paces SDRAM writes on ce, captures header, flags multicart logos.
// Optional header checksum check under CART_HDR_CHECKSUM_EN; ioctl_wait stalls the downloader per word.
module cart_hdr_loader
  import cart_pkg::*;
#(
  parameter int ADDR_W            = 25,
  parameter int NUM_PROBES        = 2,
  parameter int PROBE_STRIDE_LOG2 = 18,
  parameter int LOGO_WORDS        = 8
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  cart_download,
  input  logic                  ioctl_wr,
  input  logic [ADDR_W-1:0]     ioctl_addr,
  input  logic [15:0]           ioctl_dout,
  output logic                  ioctl_wait,
  output logic                  dn_write,
  output logic                  cart_ready,
  output logic [7:0]            mbc_type,
  output logic [7:0]            rom_size,
  output logic [7:0]            ram_size,
  output logic [7:0]            sgb_flag,
  output logic [7:0]            old_licensee,
  output logic                  cgb_flag,
  output logic [NUM_PROBES-1:0] probe_match,
  output logic                  hdr_valid,
  output logic                  hdr_chk_ok
);

  localparam int          IDX_W    = (LOGO_WORDS > 1) ? $clog2(LOGO_WORDS) : 1;
  localparam logic [11:0] LOGO_END = logo_end(LOGO_WORDS);

  cart_ld_state_t        state;
  logic                  cd_q;
  logic                  dl_rise;
  logic                  dl_fall;
  logic                  accept;
  logic                  cap;
  logic                  logo_wr;
  logic                  chk_pass;
  logic [11:0]           lo_addr;
  logic [IDX_W-1:0]      logo_idx;
  logic [15:0]           logo_ref [2**IDX_W];
  logic [NUM_PROBES-1:0] probe_res;

  assign dl_rise  = cart_download && !cd_q;
  assign dl_fall  = !cart_download && cd_q;
  assign accept   = ioctl_wr && !ioctl_wait;
  assign lo_addr  = ioctl_addr[11:0];
  assign cap      = accept && (state == LD_LOAD);
  assign logo_wr  = cap && !lo_addr[0] && (lo_addr >= LOGO_BASE) && (lo_addr < LOGO_END);
  assign logo_idx = IDX_W'((lo_addr - LOGO_BASE) >> 1);

  // A second strobe while stalled is dropped, so it never restarts the pulse.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ioctl_wait <= 1'b0;
      dn_write   <= 1'b0;
      cart_ready <= 1'b0;
    end else if (accept) begin
      ioctl_wait <= 1'b1;
    end else if (ioctl_wait && ce) begin
      if (!dn_write) begin
        dn_write <= 1'b1;
      end else begin
        dn_write   <= 1'b0;
        ioctl_wait <= 1'b0;
        cart_ready <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (logo_wr && (ioctl_addr[ADDR_W-1:12] == '0)) logo_ref[logo_idx] <= ioctl_dout;
  end

`ifdef CART_HDR_CHECKSUM_EN
  logic [7:0] chk_acc;
  logic [7:0] chk_exp;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      chk_acc <= '0;
      chk_exp <= '0;
    end else if (dl_rise) begin
      chk_acc <= '0;
      chk_exp <= '0;
    end else if (cap && (ioctl_addr[ADDR_W-1:12] == '0) && !lo_addr[0]) begin
      if ((lo_addr >= HDR_CHK_FIRST) && (lo_addr < HDR_CHK_LAST)) begin
        chk_acc <= chk_acc - ioctl_dout[7:0] - ioctl_dout[15:8] - 8'd2;
      end else if (lo_addr == HDR_CHK_LAST) begin
        chk_acc <= chk_acc - ioctl_dout[7:0] - 8'd1;
        chk_exp <= ioctl_dout[15:8];
      end
    end
  end

  assign chk_pass = (chk_acc == chk_exp);
`else
  assign chk_pass = 1'b1;
`endif

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state        <= LD_IDLE;
      cd_q         <= 1'b1;
      mbc_type     <= '0;
      rom_size     <= '0;
      ram_size     <= '0;
      sgb_flag     <= '0;
      old_licensee <= '0;
      cgb_flag     <= 1'b0;
      probe_match  <= '0;
      hdr_valid    <= 1'b0;
      hdr_chk_ok   <= 1'b0;
    end else begin
      cd_q <= cart_download;
      case (state)
        LD_LOAD: begin
          if (cap && (ioctl_addr[ADDR_W-1:12] == '0)) begin
            case (lo_addr)
              HDR_CGB:     cgb_flag <= ioctl_dout[15];
              HDR_SGB_MBC: {mbc_type, sgb_flag} <= ioctl_dout;
              HDR_SIZES:   {ram_size, rom_size} <= ioctl_dout;
              HDR_LIC:     old_licensee <= ioctl_dout[15:8];
              default: ;
            endcase
          end
          if (dl_fall) state <= LD_FINISH;
        end
        LD_FINISH: begin
          probe_match <= probe_res;
          hdr_chk_ok  <= chk_pass;
          hdr_valid   <= 1'b1;
          state       <= LD_IDLE;
        end
        default: state <= LD_IDLE;
      endcase
      if (dl_rise) begin
        state        <= LD_LOAD;
        mbc_type     <= '0;
        rom_size     <= '0;
        ram_size     <= '0;
        sgb_flag     <= '0;
        old_licensee <= '0;
        cgb_flag     <= 1'b0;
        probe_match  <= '0;
        hdr_valid    <= 1'b0;
        hdr_chk_ok   <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_PROBES; g++) begin : g_probe
    cart_logo_probe #(
      .ADDR_W    (ADDR_W),
      .LOGO_WORDS(LOGO_WORDS),
      .BASE      (ADDR_W'(g + 1) << PROBE_STRIDE_LOG2)
    ) u_probe (
      .clk_sys (clk_sys),
      .reset   (reset),
      .clr     (dl_rise),
      .wr      (logo_wr),
      .bank    (ioctl_addr[ADDR_W-1:12]),
      .dout    (ioctl_dout),
      .ref_word(logo_ref[logo_idx]),
      .match   (probe_res[g])
    );
  end

endmodule

// File: tb/tb_cart_hdr_loader.sv
// Directed bench for cart_hdr_loader; checksum expectations follow CART_HDR_CHECKSUM_EN.
module tb_cart_hdr_loader;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ce;
  logic        cart_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [15:0] ioctl_dout;
  logic        ioctl_wait;
  logic        dn_write;
  logic        cart_ready;
  logic [7:0]  mbc_type;
  logic [7:0]  rom_size;
  logic [7:0]  ram_size;
  logic [7:0]  sgb_flag;
  logic [7:0]  old_licensee;
  logic        cgb_flag;
  logic [1:0]  probe_match;
  logic        hdr_valid;
  logic        hdr_chk_ok;

  int checks = 0;
  int errors = 0;
  int timeouts = 0;

  logic [15:0] logo [8] = '{16'hEDCE, 16'h6666, 16'h0DCC, 16'h0D00,
                            16'h0B03, 16'h7300, 16'h0083, 16'h000C};

  cart_hdr_loader dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ce           (ce),
    .cart_download(cart_download),
    .ioctl_wr     (ioctl_wr),
    .ioctl_addr   (ioctl_addr),
    .ioctl_dout   (ioctl_dout),
    .ioctl_wait   (ioctl_wait),
    .dn_write     (dn_write),
    .cart_ready   (cart_ready),
    .mbc_type     (mbc_type),
    .rom_size     (rom_size),
    .ram_size     (ram_size),
    .sgb_flag     (sgb_flag),
    .old_licensee (old_licensee),
    .cgb_flag     (cgb_flag),
    .probe_match  (probe_match),
    .hdr_valid    (hdr_valid),
    .hdr_chk_ok   (hdr_chk_ok)
  );

  always #5 clk_sys = ~clk_sys;

  // One word write with a ce every other cycle until the stall drops.
  task automatic wr_word(input logic [24:0] a, input logic [15:0] d,
                         output logic seen_wait, output int pulses);
    logic prev;
    int   n;
    @(negedge clk_sys);
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d; ce = 1'b0;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    seen_wait = ioctl_wait;
    prev = dn_write;
    pulses = 0;
    n = 0;
    while (ioctl_wait && n < 20) begin
      ce = n[0];
      @(negedge clk_sys);
      if (dn_write && !prev) pulses++;
      prev = dn_write;
      n++;
    end
    ce = 1'b0;
    if (ioctl_wait) timeouts++;
  endtask

  task automatic write_logo(input logic [24:0] base, input int bad_idx);
    logic w;
    int   p;
    for (int i = 0; i < 8; i++)
      wr_word(base + 25'h104 + 25'(2 * i), logo[i] ^ ((i == bad_idx) ? 16'h0100 : 16'h0000), w, p);
  endtask

  task automatic start_load();
    @(negedge clk_sys);
    cart_download = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic end_load();
    @(negedge clk_sys);
    cart_download = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
  endtask

  task automatic test_reset();
    reset = 1'b1; cart_download = 1'b1; ioctl_wr = 1'b0; ce = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0;
    repeat (3) @(negedge clk_sys);
    checks++;
    if ({ioctl_wait, dn_write, cart_ready, cgb_flag, hdr_valid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 00000", {ioctl_wait, dn_write, cart_ready, cgb_flag, hdr_valid});
    end
    checks++;
    if ({mbc_type, rom_size, ram_size, sgb_flag, old_licensee} !== 40'h0) begin
      errors++;
      $display("FAIL reset_hdr got %h want 0", {mbc_type, rom_size, ram_size, sgb_flag, old_licensee});
    end
    checks++;
    if (probe_match !== 2'b00) begin
      errors++;
      $display("FAIL reset_probe got %b want 00", probe_match);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk_sys);
    cart_download = 1'b0;
    repeat (3) @(negedge clk_sys);
    checks++;
    if (hdr_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_held_download got hdr_valid=%b want 0", hdr_valid);
    end
  endtask

  task automatic test_basic_32k();
    logic w;
    int   p;
    int   total;
    start_load();
    wr_word(25'h146, 16'h0300, w, p);
    checks++;
    if (w !== 1'b1) begin
      errors++;
      $display("FAIL wait_rise got %b want 1", w);
    end
    checks++;
    if (p !== 1) begin
      errors++;
      $display("FAIL dn_write_pulses got %0d want 1", p);
    end
    checks++;
    if ({cart_ready, dn_write, mbc_type, hdr_valid} !== {1'b1, 1'b0, 8'h03, 1'b0}) begin
      errors++;
      $display("FAIL first_write got ready=%b dn=%b mbc=%h valid=%b want 1 0 03 0",
               cart_ready, dn_write, mbc_type, hdr_valid);
    end
    total = p;
    wr_word(25'h148, 16'h0201, w, p); total += p;
    wr_word(25'h14A, 16'h3300, w, p); total += p;
    wr_word(25'h142, 16'h8000, w, p); total += p;
    wr_word(25'h0000, 16'h1234, w, p); total += p;
    wr_word(25'h7FFE, 16'hABCD, w, p); total += p;
    checks++;
    if (total !== 6) begin
      errors++;
      $display("FAIL dn_write_total got %0d want 6", total);
    end
    end_load();
    checks++;
    if (hdr_valid !== 1'b1 || mbc_type !== 8'h03) begin
      errors++;
      $display("FAIL mbc_after_fall got valid=%b mbc=%h want 1 03", hdr_valid, mbc_type);
    end
    checks++;
    if ({rom_size, ram_size, sgb_flag, old_licensee, cgb_flag} !== {8'h01, 8'h02, 8'h00, 8'h33, 1'b1}) begin
      errors++;
      $display("FAIL hdr_fields got %h %h %h %h %b want 01 02 00 33 1",
               rom_size, ram_size, sgb_flag, old_licensee, cgb_flag);
    end
  endtask

  task automatic test_probe_dup();
    start_load();
    checks++;
    if ({hdr_valid, probe_match, mbc_type} !== 11'h0) begin
      errors++;
      $display("FAIL load_entry_clear got valid=%b probe=%b mbc=%h want 0 00 00", hdr_valid, probe_match, mbc_type);
    end
    write_logo(25'h0, -1);
    write_logo(25'h40000, -1);
    end_load();
    checks++;
    if (probe_match !== 2'b01) begin
      errors++;
      $display("FAIL probe_dup got %b want 01", probe_match);
    end
    start_load();
    write_logo(25'h0, -1);
    write_logo(25'h40000, 2);
    end_load();
    checks++;
    if (probe_match !== 2'b00) begin
      errors++;
      $display("FAIL probe_corrupt got %b want 00", probe_match);
    end
  endtask

  task automatic test_short_128k();
    logic w;
    int   p;
    start_load();
    write_logo(25'h0, -1);
    wr_word(25'h1FFFE, 16'h5555, w, p);
    end_load();
    checks++;
    if (probe_match !== 2'b00 || hdr_valid !== 1'b1) begin
      errors++;
      $display("FAIL probe_short got probe=%b valid=%b want 00 1", probe_match, hdr_valid);
    end
  endtask

  task automatic test_checksum(input logic flip);
    logic [7:0] x;
    logic [7:0] lo;
    logic [7:0] hi;
    logic       exp_ok;
    logic       w;
    int         p;
    x = 8'h00;
    start_load();
    for (int a = 'h134; a < 'h14C; a += 2) begin
      lo = 8'(a);
      hi = 8'(a + 1);
      x = x - lo - 8'd1;
      x = x - hi - 8'd1;
      wr_word(25'(a), {hi, lo}, w, p);
    end
    x = x - 8'h33 - 8'd1;
    wr_word(25'h14C, {x ^ {7'b0, flip}, 8'h33}, w, p);
    end_load();
`ifdef CART_HDR_CHECKSUM_EN
    exp_ok = !flip;
`else
    exp_ok = 1'b1;
`endif
    checks++;
    if (hdr_valid !== 1'b1 || hdr_chk_ok !== exp_ok) begin
      errors++;
      $display("FAIL checksum flip=%b got valid=%b ok=%b want 1 %b", flip, hdr_valid, hdr_chk_ok, exp_ok);
    end
  endtask

  task automatic test_reset_mid_load();
    logic w;
    int   p;
    start_load();
    wr_word(25'h146, 16'h0300, w, p);
    checks++;
    if (mbc_type !== 8'h03) begin
      errors++;
      $display("FAIL midload_capture got %h want 03", mbc_type);
    end
    @(negedge clk_sys);
    reset = 1'b1;
    @(negedge clk_sys);
    checks++;
    if ({mbc_type, cart_ready, hdr_valid, ioctl_wait, dn_write, probe_match} !== 14'h0) begin
      errors++;
      $display("FAIL midload_reset got mbc=%h ready=%b valid=%b wait=%b dn=%b probe=%b want all 0",
               mbc_type, cart_ready, hdr_valid, ioctl_wait, dn_write, probe_match);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);
    cart_download = 1'b0;
    repeat (3) @(negedge clk_sys);
    checks++;
    if (hdr_valid !== 1'b0 || mbc_type !== 8'h00) begin
      errors++;
      $display("FAIL midload_after_fall got valid=%b mbc=%h want 0 00", hdr_valid, mbc_type);
    end
  endtask

  task automatic test_back_to_back();
    int   pulses;
    logic prev;
    pulses = 0;
    @(negedge clk_sys);
    ioctl_wr = 1'b1; ce = 1'b1; ioctl_addr = 25'h200; ioctl_dout = 16'h1111;
    @(negedge clk_sys);
    checks++;
    if (ioctl_wait !== 1'b1 || dn_write !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_ce got wait=%b dn=%b want 1 0", ioctl_wait, dn_write);
    end
    prev = dn_write;
    ioctl_wr = 1'b1; ce = 1'b1;
    @(negedge clk_sys);
    if (dn_write && !prev) pulses++;
    prev = dn_write;
    checks++;
    if (ioctl_wait !== 1'b1 || dn_write !== 1'b1) begin
      errors++;
      $display("FAIL violation_first_ce got wait=%b dn=%b want 1 1", ioctl_wait, dn_write);
    end
    ioctl_wr = 1'b1; ce = 1'b0;
    @(negedge clk_sys);
    if (dn_write && !prev) pulses++;
    prev = dn_write;
    ioctl_wr = 1'b0; ce = 1'b1;
    @(negedge clk_sys);
    if (dn_write && !prev) pulses++;
    prev = dn_write;
    checks++;
    if (ioctl_wait !== 1'b0 || dn_write !== 1'b0) begin
      errors++;
      $display("FAIL violation_second_ce got wait=%b dn=%b want 0 0", ioctl_wait, dn_write);
    end
    ce = 1'b0;
    @(negedge clk_sys);
    if (dn_write && !prev) pulses++;
    checks++;
    if (pulses !== 1 || ioctl_wait !== 1'b0) begin
      errors++;
      $display("FAIL violation_pulses got pulses=%0d wait=%b want 1 0", pulses, ioctl_wait);
    end
  endtask

  initial begin
    test_reset();
    test_basic_32k();
    test_probe_dup();
    test_short_128k();
    test_checksum(1'b0);
    test_checksum(1'b1);
    test_reset_mid_load();
    test_back_to_back();
    checks++;
    if (timeouts !== 0) begin
      errors++;
      $display("FAIL handshake_timeout got %0d want 0", timeouts);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
